// File: rtl/hazard_scoreboard_pkg.sv
// rtl/hazard_scoreboard_pkg.sv - shared widths and hazard-cause encoding for the hazard controller
package hazard_scoreboard_pkg;

    // Register address width used across the core
    localparam int ADDR_WIDTH = 5;

    // Hazard cause, listed in decreasing priority
    typedef enum logic [1:0] {
        CAUSE_FREEZE = 2'd0,
        CAUSE_FLUSH  = 2'd1,
        CAUSE_STALL  = 2'd2,
        CAUSE_RUN    = 2'd3
    } hazard_cause_e;

endpackage

// File: rtl/hazard_scoreboard_sb.sv
// rtl/hazard_scoreboard_sb.sv - per-register pending-write bit vector for multi-cycle results
module reg_scoreboard #(
    parameter int ADDR_WIDTH = hazard_scoreboard_pkg::ADDR_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  set_en_i,
    input  logic [ADDR_WIDTH-1:0] set_addr_i,
    input  logic                  clr_en_i,
    input  logic [ADDR_WIDTH-1:0] clr_addr_i,
    input  logic [ADDR_WIDTH-1:0] rs1_addr_i,
    input  logic [ADDR_WIDTH-1:0] rs2_addr_i,
    input  logic [ADDR_WIDTH-1:0] waw_addr_i,
    output logic                  rs1_busy_o,
    output logic                  rs2_busy_o,
    output logic                  waw_busy_o
);

    localparam int NREG = 1 << ADDR_WIDTH;

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Next state: clear first so a same-cycle set of the same register wins; x0 never pends
    always_comb begin
        busy_d = busy_q;
        if (clr_en_i) begin
            busy_d[clr_addr_i] = 1'b0;
        end
        if (set_en_i && (set_addr_i != '0)) begin
            busy_d[set_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Pending bits, dropped wholesale on reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Read ports see only the registered state
    always_comb begin
        rs1_busy_o = busy_q[rs1_addr_i];
        rs2_busy_o = busy_q[rs2_addr_i];
        waw_busy_o = busy_q[waw_addr_i];
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - stall/flush/freeze controller with long-op scoreboard and stall counter
module hazard_scoreboard #(
    parameter int ADDR_WIDTH = hazard_scoreboard_pkg::ADDR_WIDTH,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] ID_Rs1_Addr_i,
    input  logic [ADDR_WIDTH-1:0] ID_Rs2_Addr_i,
    input  logic                  ID_Rs1_Used_i,
    input  logic                  ID_Rs2_Used_i,
    input  logic [ADDR_WIDTH-1:0] ID_Rd_Addr_i,
    input  logic                  ID_Long_i,
    input  logic                  EX_Mem_r_i,
    input  logic [ADDR_WIDTH-1:0] EX_Rd_Addr_i,
    input  logic                  EX_Branch_Taken_i,
    input  logic                  MEM_Mem_r_i,
    input  logic                  MEM_Mem_w_i,
    input  logic                  Dmem_Ready_i,
    input  logic                  Long_Done_i,
    input  logic [ADDR_WIDTH-1:0] Long_Rd_Addr_i,
    output logic                  PC_Write_o,
    output logic                  IF_ID_Write_o,
    output logic                  IF_ID_Flush_o,
    output logic                  ID_EX_Bubble_o,
    output logic                  Pipe_Freeze_o,
    output logic                  Long_Busy_o,
    output logic [CNT_WIDTH-1:0]  Stall_Count_o
);

    import hazard_scoreboard_pkg::*;

    hazard_cause_e        cause;
    logic                 mem_wait;
    logic                 load_use;
    logic                 sb_hit;
    logic                 long_issue;
    logic                 rs1_busy;
    logic                 rs2_busy;
    logic                 waw_busy;
    logic                 long_busy_q;
    logic                 long_busy_d;
    logic [CNT_WIDTH-1:0] stall_count_q;
    logic [CNT_WIDTH-1:0] stall_count_d;

    reg_scoreboard #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_sb (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .set_en_i   (long_issue),
        .set_addr_i (ID_Rd_Addr_i),
        .clr_en_i   (Long_Done_i),
        .clr_addr_i (Long_Rd_Addr_i),
        .rs1_addr_i (ID_Rs1_Addr_i),
        .rs2_addr_i (ID_Rs2_Addr_i),
        .waw_addr_i (ID_Rd_Addr_i),
        .rs1_busy_o (rs1_busy),
        .rs2_busy_o (rs2_busy),
        .waw_busy_o (waw_busy)
    );

    // Hazard detection; scoreboard hits use registered state so a result completing now still stalls once
    always_comb begin
        mem_wait = (MEM_Mem_r_i | MEM_Mem_w_i) & ~Dmem_Ready_i;
        load_use = EX_Mem_r_i & (EX_Rd_Addr_i != '0) &
                   ((ID_Rs1_Used_i & (EX_Rd_Addr_i == ID_Rs1_Addr_i)) |
                    (ID_Rs2_Used_i & (EX_Rd_Addr_i == ID_Rs2_Addr_i)));
        sb_hit   = (ID_Rs1_Used_i & rs1_busy) | (ID_Rs2_Used_i & rs2_busy) | waw_busy |
                   (ID_Long_i & long_busy_q);
    end

    // Priority encode: freeze beats branch flush beats stall beats run
    always_comb begin
        cause = CAUSE_RUN;
        if (mem_wait) begin
            cause = CAUSE_FREEZE;
        end else if (EX_Branch_Taken_i) begin
            cause = CAUSE_FLUSH;
        end else if (load_use || sb_hit) begin
            cause = CAUSE_STALL;
        end
    end

    // Control outputs decoded from the cause
    always_comb begin
        PC_Write_o     = (cause == CAUSE_RUN) || (cause == CAUSE_FLUSH);
        IF_ID_Write_o  = (cause == CAUSE_RUN) || (cause == CAUSE_FLUSH);
        IF_ID_Flush_o  = (cause == CAUSE_FLUSH);
        ID_EX_Bubble_o = (cause == CAUSE_FLUSH) || (cause == CAUSE_STALL);
        Pipe_Freeze_o  = (cause == CAUSE_FREEZE);
        Long_Busy_o    = long_busy_q;
        Stall_Count_o  = stall_count_q;
    end

    // A long op leaves ID only on a clean run cycle
    always_comb begin
        long_issue  = ID_Long_i && (cause == CAUSE_RUN);
        long_busy_d = long_busy_q;
        if (long_issue) begin
            long_busy_d = 1'b1;
        end else if (Long_Done_i) begin
            long_busy_d = 1'b0;
        end
        stall_count_d = stall_count_q;
        if (((cause == CAUSE_FREEZE) || (cause == CAUSE_STALL)) && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // Long-op busy flag and saturating stall counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            long_busy_q   <= 1'b0;
            stall_count_q <= '0;
        end else begin
            long_busy_q   <= long_busy_d;
            stall_count_q <= stall_count_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - randomized and directed self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1, rs2, id_rd, ex_rd, l_rd;
    logic       rs1_used, rs2_used, id_long, ex_mem_r, br_taken;
    logic       mem_r, mem_w, dmem_ready, l_done;

    logic        pc_w, ifid_w, ifid_fl, idex_bub, freeze, lbusy;
    logic [31:0] cnt;
    logic        pc_w4, ifid_w4, ifid_fl4, idex_bub4, freeze4, lbusy4;
    logic [3:0]  cnt4;

    // Reference state
    bit [31:0] m_sb;
    bit        m_busy;
    longint    m_cnt;

    // Last sampled outputs for directed checks
    bit s_pc, s_ifw, s_fl, s_bub, s_frz, s_lb;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk_i(clk), .rst_i(rst),
        .ID_Rs1_Addr_i(rs1), .ID_Rs2_Addr_i(rs2),
        .ID_Rs1_Used_i(rs1_used), .ID_Rs2_Used_i(rs2_used),
        .ID_Rd_Addr_i(id_rd), .ID_Long_i(id_long),
        .EX_Mem_r_i(ex_mem_r), .EX_Rd_Addr_i(ex_rd), .EX_Branch_Taken_i(br_taken),
        .MEM_Mem_r_i(mem_r), .MEM_Mem_w_i(mem_w), .Dmem_Ready_i(dmem_ready),
        .Long_Done_i(l_done), .Long_Rd_Addr_i(l_rd),
        .PC_Write_o(pc_w), .IF_ID_Write_o(ifid_w), .IF_ID_Flush_o(ifid_fl),
        .ID_EX_Bubble_o(idex_bub), .Pipe_Freeze_o(freeze), .Long_Busy_o(lbusy),
        .Stall_Count_o(cnt)
    );

    hazard_scoreboard #(.CNT_WIDTH(4)) dut_sat (
        .clk_i(clk), .rst_i(rst),
        .ID_Rs1_Addr_i(rs1), .ID_Rs2_Addr_i(rs2),
        .ID_Rs1_Used_i(rs1_used), .ID_Rs2_Used_i(rs2_used),
        .ID_Rd_Addr_i(id_rd), .ID_Long_i(id_long),
        .EX_Mem_r_i(ex_mem_r), .EX_Rd_Addr_i(ex_rd), .EX_Branch_Taken_i(br_taken),
        .MEM_Mem_r_i(mem_r), .MEM_Mem_w_i(mem_w), .Dmem_Ready_i(dmem_ready),
        .Long_Done_i(l_done), .Long_Rd_Addr_i(l_rd),
        .PC_Write_o(pc_w4), .IF_ID_Write_o(ifid_w4), .IF_ID_Flush_o(ifid_fl4),
        .ID_EX_Bubble_o(idex_bub4), .Pipe_Freeze_o(freeze4), .Long_Busy_o(lbusy4),
        .Stall_Count_o(cnt4)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // What the pipe must do this cycle, from the priority rules and the model state
    task automatic expect_now(output bit e_frz, output bit e_fl, output bit e_stall);
        bit mw, lu, sbh;
        mw  = (mem_r || mem_w) && !dmem_ready;
        lu  = ex_mem_r && (ex_rd != 0) &&
              ((rs1_used && ex_rd == rs1) || (rs2_used && ex_rd == rs2));
        sbh = (rs1_used && m_sb[rs1]) || (rs2_used && m_sb[rs2]) || m_sb[id_rd] ||
              (id_long && m_busy);
        e_frz   = mw;
        e_fl    = !mw && br_taken;
        e_stall = !mw && !br_taken && (lu || sbh);
    endtask

    task automatic compare_outputs();
        bit f, fl, st;
        longint sat4;
        expect_now(f, fl, st);
        sat4 = (m_cnt > 15) ? 15 : m_cnt;
        chk("pc_write",  pc_w,     !(f || st));
        chk("ifid_write", ifid_w,  !(f || st));
        chk("ifid_flush", ifid_fl, fl);
        chk("idex_bubble", idex_bub, fl || st);
        chk("pipe_freeze", freeze, f);
        chk("long_busy", lbusy,    m_busy);
        chk("stall_count", cnt,    m_cnt);
        chk("pc_write_w4", pc_w4,  !(f || st));
        chk("long_busy_w4", lbusy4, m_busy);
        chk("stall_count_w4", cnt4, sat4);
        s_pc = pc_w; s_ifw = ifid_w; s_fl = ifid_fl; s_bub = idex_bub;
        s_frz = freeze; s_lb = lbusy;
    endtask

    task automatic model_update();
        bit f, fl, st, issue;
        expect_now(f, fl, st);
        if (rst) begin
            m_sb = '0; m_busy = 0; m_cnt = 0;
        end else begin
            issue = id_long && !f && !fl && !st;
            if (l_done) m_sb[l_rd] = 1'b0;
            if (issue && id_rd != 0) m_sb[id_rd] = 1'b1;
            if (issue) m_busy = 1'b1;
            else if (l_done) m_busy = 1'b0;
            if (f || st) m_cnt = m_cnt + 1;
        end
    endtask

    // One clock: inputs are already set; check at the falling edge, advance model at the rising edge
    task automatic cycle();
        @(negedge clk);
        compare_outputs();
        @(posedge clk);
        model_update();
        cyc++;
        #1;
    endtask

    task automatic set_idle();
        rs1 = 0; rs2 = 0; id_rd = 0; ex_rd = 0; l_rd = 0;
        rs1_used = 0; rs2_used = 0; id_long = 0; ex_mem_r = 0; br_taken = 0;
        mem_r = 0; mem_w = 0; dmem_ready = 1; l_done = 0;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1;
        cycle();
        rst = 0;
    endtask

    initial begin
        int stalls, frz_n, fl_n;
        m_sb = '0; m_busy = 0; m_cnt = 0;
        do_reset();

        // Reset state
        cycle();
        chk("rst_pc", s_pc, 1); chk("rst_ifw", s_ifw, 1); chk("rst_flush", s_fl, 0);
        chk("rst_bubble", s_bub, 0); chk("rst_freeze", s_frz, 0); chk("rst_busy", s_lb, 0);
        chk("rst_count", cnt, 0);

        // Load-use on x5
        do_reset();
        ex_mem_r = 1; ex_rd = 5; rs1 = 5; rs1_used = 1; id_rd = 6;
        cycle();
        chk("lu_pc", s_pc, 0); chk("lu_bubble", s_bub, 1);
        ex_mem_r = 0; ex_rd = 0;
        cycle();
        chk("lu_release", s_pc, 1);
        chk("lu_count", cnt, 1);

        // Load to x0 never stalls
        do_reset();
        ex_mem_r = 1; ex_rd = 0; rs1 = 0; rs1_used = 1; rs2 = 0; rs2_used = 1;
        cycle();
        chk("x0_pc", s_pc, 1);

        // DIV x7 dependence, completion 8 cycles after issue
        do_reset();
        id_long = 1; id_rd = 7;
        cycle();
        chk("div_issue_pc", s_pc, 1);
        id_long = 0; id_rd = 8; rs1 = 7; rs1_used = 1; l_rd = 7;
        stalls = 0;
        for (int i = 1; i <= 8; i++) begin
            l_done = (i == 8);
            cycle();
            if (!s_pc) stalls++;
        end
        l_done = 0;
        cycle();
        chk("div_stalls", stalls, 8);
        chk("div_release", s_pc, 1);
        chk("div_busy_after", s_lb, 0);
        chk("div_count", cnt, 8);

        // Freeze hides a taken branch, flush follows
        do_reset();
        mem_r = 1; dmem_ready = 0; br_taken = 1;
        frz_n = 0; fl_n = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            frz_n += s_frz; fl_n += s_fl;
        end
        chk("frz_cycles", frz_n, 3); chk("frz_noflush", fl_n, 0);
        dmem_ready = 1;
        cycle();
        chk("frz_flush", s_fl, 1); chk("frz_after", s_frz, 0);
        chk("frz_count", cnt, 3);

        // Stale completion of x3 together with a fresh DIV x3 issue: set wins
        do_reset();
        id_long = 1; id_rd = 3; l_done = 1; l_rd = 3;
        cycle();
        chk("sim_issue", s_pc, 1);
        set_idle(); rs1 = 3; rs1_used = 1; id_rd = 4;
        cycle();
        chk("sim_bit3", s_pc, 0); chk("sim_busy", s_lb, 1);

        // Saturation of the narrow counter, then reset with a DIV outstanding
        do_reset();
        mem_w = 1; dmem_ready = 0;
        for (int i = 0; i < 20; i++) cycle();
        chk("sat_w4", cnt4, 15); chk("sat_w32", cnt, 20);
        set_idle(); id_long = 1; id_rd = 9;
        cycle();
        set_idle(); rst = 1;
        cycle();
        rst = 0; rs1 = 9; rs1_used = 1; id_long = 1; id_rd = 10;
        cycle();
        chk("rst_mid_pc", s_pc, 1);
        chk("rst_mid_busy", s_lb, 0);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 199) == 0);
            rs1        = 5'($urandom_range(0, 7));
            rs2        = 5'($urandom_range(0, 7));
            id_rd      = 5'($urandom_range(0, 7));
            ex_rd      = 5'($urandom_range(0, 7));
            l_rd       = 5'($urandom_range(0, 7));
            rs1_used   = $urandom_range(0, 3) != 0;
            rs2_used   = $urandom_range(0, 1) != 0;
            id_long    = $urandom_range(0, 3) == 0;
            ex_mem_r   = $urandom_range(0, 3) == 0;
            br_taken   = $urandom_range(0, 9) == 0;
            mem_r      = $urandom_range(0, 3) == 0;
            mem_w      = $urandom_range(0, 5) == 0;
            dmem_ready = $urandom_range(0, 9) < 7;
            l_done     = $urandom_range(0, 4) == 0;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Pipeline hazard controller for the 5-stage RISC-V core; the stall/flush counterpart to the EX-stage operand bypass. It is the producer-side authority on when a result is not yet forwardable. It detects load-use hazards, tracks in-flight multi-cycle MUL/DIV destinations in a per-register scoreboard, freezes the pipe while data memory is not ready, and kills wrong-path instructions on taken branches. It sits beside the ID stage and drives the write-enables and bubble/flush controls of the PC and the pipeline registers.

## Interface
- ADDR_WIDTH, 5, register address width (matches `ADDR_WIDTH` in SYSTEM_DEF.vh)
- CNT_WIDTH, 32, stall counter width
- clk  in  1  core clock; one clock domain
- rst  in  1  reset, synchronous, active-high
- ID_Rs1_Addr, ID_Rs2_Addr  in  ADDR_WIDTH  source registers of the instruction in ID
- ID_Rs1_Used, ID_Rs2_Used  in  1  source actually read by the ID instruction
- ID_Rd_Addr  in  ADDR_WIDTH  destination of the ID instruction
- ID_Long  in  1  ID instruction is a multi-cycle MUL/DIV
- EX_Mem_r  in  1  instruction in EX is a load
- EX_Rd_Addr  in  ADDR_WIDTH  destination of the EX instruction
- EX_Branch_Taken  in  1  branch/jump resolved taken in EX
- MEM_Mem_r, MEM_Mem_w  in  1  load/store in MEM
- Dmem_Ready  in  1  data memory completes the MEM access this cycle
- Long_Done  in  1  MUL/DIV unit writes its result this cycle
- Long_Rd_Addr  in  ADDR_WIDTH  destination of the completing MUL/DIV
- PC_Write  out  1  PC may update
- IF_ID_Write  out  1  IF/ID register may load
- IF_ID_Flush  out  1  IF/ID register loads a NOP
- ID_EX_Bubble  out  1  ID/EX register loads a NOP
- Pipe_Freeze  out  1  ID/EX, EX/MEM and MEM/WB hold their contents
- Long_Busy  out  1  a MUL/DIV is outstanding
- Stall_Count  out  CNT_WIDTH  saturating count of stalled cycles

## Operation
- The control outputs are combinational and evaluated in strict priority order.
- **1. MEM wait.** Condition: (MEM_Mem_r|MEM_Mem_w) & !Dmem_Ready.
  - Outputs: Pipe_Freeze=1, PC_Write=0, IF_ID_Write=0, IF_ID_Flush=0, ID_EX_Bubble=0.
  - A taken branch during the freeze is suppressed; it re-asserts once the pipe moves.
- **2. Branch.** Condition: EX_Branch_Taken.
  - Outputs: IF_ID_Flush=1, ID_EX_Bubble=1, PC_Write=1, IF_ID_Write=1.
  - Any hazard raised by the killed ID instruction is ignored.
- **3. Load-use.** Condition: EX_Mem_r & EX_Rd_Addr!=0 & EX_Rd_Addr equals a used ID source.
  - Outputs: PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1.
  - Lasts exactly one cycle; the bypass covers the load once it reaches MEM/WB.
- **4. Scoreboard.** Condition is either of:
  - the scoreboard bit is set for a used ID source, or for ID_Rd_Addr (WAW), or
  - ID_Long & Long_Busy.
  - Outputs: same as load-use.
- **5. Run.** PC_Write=1, IF_ID_Write=1, all other control outputs 0.
- **Scoreboard:** 2^ADDR_WIDTH bits; bit 0 is never set.
  - Set: ID_Rd_Addr's bit, when ID_Long and the instruction advances into EX (no bubble, no freeze, no flush) and ID_Rd_Addr!=0.
  - Clear: Long_Rd_Addr's bit, on Long_Done.
  - Same register set and cleared in one cycle: set wins.
- **Long_Busy:** registered.
  - Sets on a long issue, including rd=0.
  - Clears on Long_Done, unless a new long op issues in that same cycle.
- **Stall checks** use the registered scoreboard and Long_Busy only. A register cleared this cycle stalls one more cycle; its value then comes from WB forwarding.
- **Stall_Count:** +1 on each cycle with PC_Write=0 (priorities 1, 3, 4); saturates at all-ones; never wraps.

## Timing
- Hazard outputs have zero-cycle latency, i.e. are valid in the same cycle as their inputs. The scoreboard, Long_Busy and Stall_Count update on the rising clk edge.
- State after reset:
  - scoreboard all 0, Long_Busy=0, Stall_Count=0;
  - outputs at run values (PC_Write=1, IF_ID_Write=1, others 0), subject to inputs.
- rst asserted mid-operation discards all pending bits in that edge; in-flight Long_Done after reset is ignored for clearing purposes (bits already 0).
- Load-use stall costs 1 cycle; a long-op dependence stalls from issue+1 until the cycle after Long_Done.
- A freeze of N cycles adds exactly N to Stall_Count.

## Structure
- Shared package/header (SYSTEM_DEF.vh):
  - ADDR_WIDTH;
  - the priority encoding, as a 2-bit hazard-cause code: FREEZE, FLUSH, STALL, RUN.
- Natural sub-module: reg_scoreboard (bit vector with set/clear ports and two read ports plus a WAW read port).
- The priority logic and Stall_Count stay in the top module.

## Test plan
- **Load-use:** EX load to x5, ID add reads x5 → exactly 1 cycle with PC_Write=0 and ID_EX_Bubble=1; Stall_Count=1.
- **rd=x0:** EX load to x0, ID reads x0 → no stall.
- **DIV dependence:** DIV x7 issues, Long_Done for x7 arrives 8 cycles later, dependent add in ID → stalls until the cycle after Long_Done; bit 7 is 0 afterwards.
- **Freeze vs branch:** MEM load with Dmem_Ready=0 for 3 cycles while EX_Branch_Taken=1 → Pipe_Freeze=1 for 3 cycles with no flush, then one flush cycle; Stall_Count=3.
- **Simultaneous completion/issue:** Long_Done(x3) together with a new DIV x3 issue → bit 3 stays set and Long_Busy stays 1.
- **Saturation and reset:** preload the count near the limit with CNT_WIDTH=4 and stall 20 cycles → Stall_Count=15. Then rst during an outstanding DIV → all bits 0 and Long_Busy=0 next cycle.
